// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: read-owner tags, FSM states,
// one-hot winner bit positions and the default starvation threshold.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PC   = 2'd1,
    OWN_EX   = 2'd2,
    OWN_DM   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    LOCK  = 2'd2
  } state_e;

  // bit positions inside the one-hot winner vector
  localparam int W_PC = 0;
  localparam int W_EX = 1;
  localparam int W_DM = 2;

  localparam int PC_STARVE_MAX_DEF = 4;

  // one-hot winner -> owner tag (NONE when nobody won)
  function automatic owner_e win2owner(input logic [2:0] win);
    owner_e o;
    o = OWN_NONE;
    if (win[W_DM])      o = OWN_DM;
    else if (win[W_EX]) o = OWN_EX;
    else if (win[W_PC]) o = OWN_PC;
    return o;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the three requester ports, the lock handshake and the SRAM
// macro side. slave = arbiter view, master = requesters + memory view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              pc_req_i;
  logic [ADDR_W-1:0] pc_addr_i;
  logic              pc_gnt_o;
  logic              pc_rvalid_o;
  logic [DATA_W-1:0] pc_rdata_o;

  logic              ex_req_i;
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_gnt_o;
  logic              ex_rvalid_o;
  logic [DATA_W-1:0] ex_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_lock_i;
  logic              dm_locked_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-3:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  pc_req_i, pc_addr_i,
    output pc_gnt_o, pc_rvalid_o, pc_rdata_o,
    input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
    output ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_lock_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_locked_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output pc_req_i, pc_addr_i,
    input  pc_gnt_o, pc_rvalid_o, pc_rdata_o,
    output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
    input  ex_gnt_o, ex_rvalid_o, ex_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_lock_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_locked_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/sram_arb_prio.sv
// Combinational 3-way pick: dm > ex > pc, except a starved pc jumps ex.
module sram_arb_prio
  import sram_arbiter_pkg::*;
(
  input  logic       pc_req_i,
  input  logic       ex_req_i,
  input  logic       dm_req_i,
  input  logic       pc_starved_i,
  output logic [2:0] win_o
);

  // one-hot winner selection
  always_comb begin
    win_o = '0;
    if (dm_req_i)                      win_o[W_DM] = 1'b1;
    else if (pc_req_i && pc_starved_i) win_o[W_PC] = 1'b1;
    else if (ex_req_i)                 win_o[W_EX] = 1'b1;
    else if (pc_req_i)                 win_o[W_PC] = 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between pc, ex and dm.
// Grants are combinational; read data returns one cycle later to the
// owner recorded in owner_q. dm can take exclusive ownership (LOCK),
// passing through DRAIN when a read is still in flight.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int PC_STARVE_MAX = PC_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  sram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(PC_STARVE_MAX + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [2:0]        win, gnt;
  logic              starved, rd_issue;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              addr_lo_unused;

  assign starved = (starve_q == CNT_W'(PC_STARVE_MAX));

  sram_arb_prio u_prio (
    .pc_req_i     (bus.pc_req_i),
    .ex_req_i     (bus.ex_req_i),
    .dm_req_i     (bus.dm_req_i),
    .pc_starved_i (starved),
    .win_o        (win)
  );

  // grant gating by FSM state; nothing is granted while reset is held
  always_comb begin
    gnt = '0;
    if (rst) begin
      case (state_q)
        ARB:     gnt = win;
        LOCK:    gnt[W_DM] = bus.dm_req_i;
        default: gnt = '0;
      endcase
    end
  end

  // steer the winner onto the memory port; zeros when idle
  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt[W_DM]) begin
      we_sel    = bus.dm_we_i;
      addr_sel  = bus.dm_addr_i;
      wdata_sel = bus.dm_wdata_i;
    end else if (gnt[W_EX]) begin
      we_sel    = bus.ex_we_i;
      addr_sel  = bus.ex_addr_i;
      wdata_sel = bus.ex_wdata_i;
    end else if (gnt[W_PC]) begin
      addr_sel  = bus.pc_addr_i;
    end
  end

  assign rd_issue       = (|gnt) & ~we_sel;
  assign addr_lo_unused = ^addr_sel[1:0];

  // next state, next read owner and starvation counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (bus.dm_lock_i) state_d = rd_issue ? DRAIN : LOCK;
      DRAIN:   state_d = bus.dm_lock_i ? LOCK : ARB;
      LOCK:    if (!bus.dm_lock_i) state_d = ARB;
      default: state_d = ARB;
    endcase

    owner_d = rd_issue ? win2owner(gnt) : OWN_NONE;

    starve_d = starve_q;
    if (!bus.pc_req_i || gnt[W_PC])       starve_d = '0;
    else if (state_q == ARB && !starved)  starve_d = starve_q + 1'b1;
    if (state_d == LOCK && state_q != LOCK) starve_d = '0;
  end

  // state registers; reset drops any read in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign bus.pc_gnt_o    = gnt[W_PC];
  assign bus.ex_gnt_o    = gnt[W_EX];
  assign bus.dm_gnt_o    = gnt[W_DM];
  assign bus.pc_rvalid_o = (owner_q == OWN_PC);
  assign bus.ex_rvalid_o = (owner_q == OWN_EX);
  assign bus.dm_rvalid_o = (owner_q == OWN_DM);
  assign bus.pc_rdata_o  = bus.pc_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.ex_rdata_o  = bus.ex_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.dm_locked_o = (state_q == LOCK);
  assign bus.mem_ce_o    = |gnt;
  assign bus.mem_we_o    = (|gnt) & we_sel;
  assign bus.mem_addr_o  = addr_sel[ADDR_W-1:2];
  assign bus.mem_wdata_o = wdata_sel;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Single-cycle arbiter that shares one single-port synchronous SRAM between three requesters: instruction fetch (pc), execute-stage load/store (ex) and the debug module (dm). It sits between the core/debug interfaces and the memory macro. It issues at most one access per cycle and returns read data one cycle later to the owner of that access. Fixed priority is dm > ex > pc, with pc starvation relief and an exclusive dm lock mode for debug bursts.

## Interface
- ADDR_W, 32: byte address width of all requester ports.
- DATA_W, 32: data word width.
- PC_STARVE_MAX, 4: consecutive denied pc cycles after which pc outranks ex.

Ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- pc_req_i  in  1  pc read request.
- pc_addr_i  in  ADDR_W  pc byte address.
- pc_gnt_o  out  1  pc request accepted this cycle.
- pc_rvalid_o  out  1  pc read data valid.
- pc_rdata_o  out  DATA_W  pc read data.
- ex_req_i, ex_we_i  in  1 each  ex request and write enable.
- ex_addr_i  in  ADDR_W  ex byte address.
- ex_wdata_i  in  DATA_W  ex write data.
- ex_gnt_o, ex_rvalid_o  out  1 each  ex grant and read valid.
- ex_rdata_o  out  DATA_W  ex read data.
- dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_gnt_o, dm_rvalid_o, dm_rdata_o: same shape as ex.
- dm_lock_i  in  1  dm requests exclusive ownership.
- dm_locked_o  out  1  exclusive ownership in effect.
- mem_ce_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W-2  word address, equal to granted addr[ADDR_W-1:2].
- mem_wdata_o  out  DATA_W  write data.
- mem_rdata_i  in  DATA_W  read data, valid the cycle after a read strobe.

## Operation
- FSM states: ARB, DRAIN, LOCK. Reset state is ARB.
- ARB:
  - At most one grant per cycle. The winner is dm if dm_req_i is high.
  - Otherwise the winner is pc if pc_req_i is high and starve_cnt == PC_STARVE_MAX.
  - Otherwise the winner is ex if ex_req_i is high, else pc if pc_req_i is high.
- ARB to LOCK/DRAIN: when dm_lock_i=1, go to DRAIN if a read is outstanding (issued this cycle), else go to LOCK.
  - In the transition cycle itself, arbitration still proceeds normally.
- DRAIN: lasts exactly 1 cycle. No grants. Returns the outstanding read, then goes to LOCK.
- LOCK:
  - dm_locked_o=1. Only dm is granted. pc and ex gnt_o are held 0.
  - dm_lock_i=0 returns to ARB on the next cycle.
  - If dm_lock_i is dropped while in DRAIN, go to ARB instead of LOCK.
- Grant is combinational from the request in the same cycle. mem_ce_o, mem_we_o, mem_addr_o and mem_wdata_o are driven from the winner in that cycle.
- A requester holds req, we, addr and wdata stable until it sees gnt.
- Read return:
  - A 2-bit owner register (NONE/PC/EX/DM) records the winner of a read.
  - The next cycle, that owner's rvalid_o=1 and rdata_o=mem_rdata_i.
  - A non-owner's rdata_o is 0.
  - Writes record NONE and produce no rvalid.
- Starvation counter starve_cnt, width $clog2(PC_STARVE_MAX+1):
  - Saturating increment on pc_req_i && !pc_gnt_o while in ARB.
  - Cleared on pc_gnt_o, on !pc_req_i, and on entry to LOCK.
- Simultaneous return and grant: a read returning in cycle N+1 does not block a new grant in N+1. The owner register is overwritten with the new winner in N+1.

## Timing
- Reset values: all gnt_o, rvalid_o, mem_ce_o, mem_we_o and dm_locked_o are 0. All rdata_o are 0. mem_addr_o and mem_wdata_o are 0 when no grant.
- Internal state at reset: owner=NONE, starve_cnt=0, state=ARB.
- Reset asserted mid-operation: the outstanding read is discarded and no rvalid is produced after reset release.
- Latency:
  - Grant: 0 cycles.
  - Read data: 1 cycle after grant.
  - Write: committed at the clock edge ending the grant cycle.
  - Lock entry: 1 cycle from dm_lock_i (2 cycles when draining).
  - Lock exit: 1 cycle.
- Throughput: one access per cycle. Back-to-back reads to different owners are legal.

## Structure
- Shared package (defines): owner encoding NONE=0, PC=1, EX=2, DM=3; FSM state encoding; default PC_STARVE_MAX.
- One natural sub-module, sram_arb_prio: the combinational 3-way priority pick with starvation override, producing a one-hot winner.
- The FSM, owner register and counter stay in the top module.

## Test plan
- Single reads: pc reads 0x100 while memory holds 0xDEADBEEF → pc_gnt_o same cycle, mem_addr_o=0x40; next cycle pc_rvalid_o=1, pc_rdata_o=0xDEADBEEF, and ex/dm rvalid stay 0.
- Priority: dm, ex and pc all request in one cycle → dm granted. Next cycle (dm dropped) → ex granted, then pc. Each read returns to its own requester one cycle after its grant.
- Starvation: ex requests continuously and pc requests continuously, PC_STARVE_MAX=4 → pc denied 4 cycles, granted on the 5th, then starve_cnt=0 and ex resumes.
- Lock with drain: ex read granted in cycle N while dm_lock_i rises in N → DRAIN in N+1 with ex_rvalid_o=1, LOCK in N+2 with dm_locked_o=1. pc/ex requests are not granted until dm_lock_i=0 plus 1 cycle.
- Write then read: ex writes 0x12345678 to 0x200, then dm reads 0x200 → no rvalid on the write; dm_rdata_o=0x12345678 one cycle after the dm grant.
- Reset mid-read: rst=0 in the cycle after a pc read grant → all outputs 0 immediately; after release, no stale pc_rvalid_o and state=ARB.
